// File: rtl/perm_fetch_scheduler.sv
// Read sequencer for one FFT pass through the 16-bank skewed memory.
// Issues one shared chunk address per cycle and aligns bank_num and cycle_count with the returning data.
module perm_fetch_scheduler #(
   parameter int BANK_COUNT = 16,
   parameter int BANK_W     = 4,
   parameter int ADDR_W     = 12,
   parameter int MEM_LAT    = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [ADDR_W-1:0]            num_chunks,
   input  logic                         stall,
   output logic                         busy,
   output logic                         done,
   output logic                         mem_rd_en,
   output logic [ADDR_W-1:0]            mem_addr,
   output logic                         fft_enable,
   output logic [ADDR_W-1:0]            cycle_count,
   output logic [BANK_COUNT*BANK_W-1:0] bank_num
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_DRAIN = 3'd2,
      ST_DONE  = 3'd3,
      ST_EMPTY = 3'd4
   } state_t;

   state_t              state_r;
   logic [ADDR_W-1:0]   chunk_r;
   logic [ADDR_W-1:0]   last_r;
   logic                tap_en_s;
   logic [ADDR_W-1:0]   tap_addr_s;
   logic                pending_s;

   // Lane i reads from bank (chunk + i) mod BANK_COUNT; the BANK_W-bit add wraps naturally.
   function automatic logic [BANK_COUNT*BANK_W-1:0] lane_map(input logic [ADDR_W-1:0] addr);
      logic [BANK_COUNT*BANK_W-1:0] m;
      m = '0;
      for (int i = 0; i < BANK_COUNT; i++) begin
         m[i*BANK_W +: BANK_W] = addr[BANK_W-1:0] + BANK_W'(i);
      end
      return m;
   endfunction

   // Pass control: accept start, issue one read per unstalled cycle, drain, pulse done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         chunk_r   <= '0;
         last_r    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         mem_rd_en <= 1'b0;
         mem_addr  <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done      <= 1'b0;
               busy      <= 1'b0;
               mem_rd_en <= 1'b0;
               if (start) begin
                  if (num_chunks != '0) begin
                     state_r <= ST_RUN;
                     last_r  <= num_chunks - ADDR_W'(1);
                     chunk_r <= '0;
                     busy    <= 1'b1;
                  end else begin
                     state_r <= ST_EMPTY;
                  end
               end
            end
            ST_RUN: begin
               if (!stall) begin
                  mem_rd_en <= 1'b1;
                  mem_addr  <= chunk_r;
                  chunk_r   <= chunk_r + ADDR_W'(1);
                  if (chunk_r == last_r) begin
                     state_r <= ST_DRAIN;
                  end
               end else begin
                  mem_rd_en <= 1'b0;
               end
            end
            ST_DRAIN: begin
               mem_rd_en <= 1'b0;
               // busy is forced here so the empty pass shows busy only in its done cycle
               if (!pending_s) begin
                  done    <= 1'b1;
                  busy    <= 1'b1;
                  state_r <= ST_DONE;
               end
            end
            ST_EMPTY: begin
               mem_rd_en <= 1'b0;
               state_r   <= ST_DRAIN;
            end
            ST_DONE: begin
               done      <= 1'b0;
               busy      <= 1'b0;
               mem_rd_en <= 1'b0;
               state_r   <= ST_IDLE;
            end
            default: begin
               state_r   <= ST_IDLE;
               busy      <= 1'b0;
               done      <= 1'b0;
               mem_rd_en <= 1'b0;
            end
         endcase
      end
   end

   generate
      if (MEM_LAT == 1) begin : g_lat1
         assign tap_en_s   = mem_rd_en;
         assign tap_addr_s = mem_addr;
         assign pending_s  = mem_rd_en;
      end else begin : g_latn
         logic [MEM_LAT-2:0] pen_r;
         logic [ADDR_W-1:0]  paddr_r [MEM_LAT-1];

         // Intermediate delay stages between the read strobe and the output stage.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               pen_r <= '0;
               for (int k = 0; k < MEM_LAT-1; k++) begin
                  paddr_r[k] <= '0;
               end
            end else begin
               pen_r[0]   <= mem_rd_en;
               paddr_r[0] <= mem_addr;
               for (int k = 1; k < MEM_LAT-1; k++) begin
                  pen_r[k]   <= pen_r[k-1];
                  paddr_r[k] <= paddr_r[k-1];
               end
            end
         end

         assign tap_en_s   = pen_r[MEM_LAT-2];
         assign tap_addr_s = paddr_r[MEM_LAT-2];
         assign pending_s  = mem_rd_en | (|pen_r);
      end
   endgenerate

   // Final delay stage: data valid strobe plus the lane map for the chunk now at the banks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fft_enable  <= 1'b0;
         cycle_count <= '0;
         bank_num    <= '0;
      end else begin
         fft_enable <= tap_en_s;
         if (tap_en_s) begin
            cycle_count <= tap_addr_s;
            bank_num    <= lane_map(tap_addr_s);
         end
      end
   end

endmodule

// File: tb/tb_perm_fetch_scheduler.sv
// Randomized bench for perm_fetch_scheduler at MEM_LAT 1 and 3, checked every cycle
// against a timeline model of passes, plus directed hand-computed expectations.
module tb_perm_fetch_scheduler;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [11:0] num;
   logic        stall;

   logic        busy0, done0, rd0, fft0;
   logic [11:0] addr0, cc0;
   logic [63:0] bank0;
   logic        busy1, done1, rd1, fft1;
   logic [11:0] addr1, cc1;
   logic [63:0] bank1;

   int n_checks = 0;
   int n_errors = 0;

   perm_fetch_scheduler #(.BANK_COUNT(16), .BANK_W(4), .ADDR_W(12), .MEM_LAT(1)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start), .num_chunks(num), .stall(stall),
      .busy(busy0), .done(done0), .mem_rd_en(rd0), .mem_addr(addr0),
      .fft_enable(fft0), .cycle_count(cc0), .bank_num(bank0));

   perm_fetch_scheduler #(.BANK_COUNT(16), .BANK_W(4), .ADDR_W(12), .MEM_LAT(3)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start), .num_chunks(num), .stall(stall),
      .busy(busy1), .done(done1), .mem_rd_en(rd1), .mem_addr(addr1),
      .fft_enable(fft1), .cycle_count(cc1), .bank_num(bank1));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, got, exp);
      end
   endtask

   // ---------------- behavioural model: one timeline per DUT ----------------
   int          t = 0;
   int          m_lat [2] = '{1, 3};
   bit          m_active [2];
   bit          m_empty [2];
   int          m_start [2];
   int          m_done [2];
   int          m_rem [2];
   int          m_next [2];
   bit          m_rd [2];
   logic [11:0] m_addr [2];
   bit          m_fft [2];
   logic [11:0] m_cc [2];
   logic [63:0] m_bank [2];
   bit          m_busy [2];
   bit          m_doneo [2];
   bit          en_hist [2][16];
   logic [11:0] addr_hist [2][16];

   function automatic logic [63:0] lanes(input logic [11:0] c);
      logic [63:0] m;
      for (int i = 0; i < 16; i++) m[i*4 +: 4] = 4'((int'(c) + i) % 16);
      return m;
   endfunction

   task automatic model_step();
      t++;
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            m_active[d] = 0; m_empty[d] = 0; m_done[d] = -100; m_rem[d] = 0;
            m_rd[d] = 0; m_addr[d] = '0; m_fft[d] = 0; m_cc[d] = '0; m_bank[d] = '0;
            m_busy[d] = 0; m_doneo[d] = 0;
            for (int h = 0; h < 16; h++) begin en_hist[d][h] = 0; addr_hist[d][h] = '0; end
         end else begin
            if (!m_active[d] && start && t >= m_done[d] + 2) begin
               m_active[d] = 1; m_start[d] = t; m_empty[d] = (num == 0);
               m_rem[d] = int'(num); m_next[d] = 0;
               m_done[d] = m_empty[d] ? t + 2 : 32'h3fffffff;
            end
            m_rd[d] = 0;
            if (m_active[d] && t > m_start[d] && m_rem[d] > 0 && !stall) begin
               m_rd[d] = 1; m_addr[d] = 12'(m_next[d]);
               m_next[d]++; m_rem[d]--;
               if (m_rem[d] == 0) m_done[d] = t + m_lat[d] + 1;
            end
            en_hist[d][t % 16] = m_rd[d];
            addr_hist[d][t % 16] = m_addr[d];
            m_fft[d] = en_hist[d][(t + 16 - m_lat[d]) % 16];
            if (m_fft[d]) begin
               m_cc[d] = addr_hist[d][(t + 16 - m_lat[d]) % 16];
               m_bank[d] = lanes(m_cc[d]);
            end
            m_doneo[d] = m_active[d] && (t == m_done[d]);
            m_busy[d] = m_active[d] && (m_empty[d] ? (t == m_done[d]) : (t <= m_done[d]));
            if (m_active[d] && t == m_done[d]) m_active[d] = 0;
         end
      end
   endtask

   task automatic cmp(input int d, input logic b, input logic dn, input logic rd,
                      input logic [11:0] a, input logic f, input logic [11:0] c,
                      input logic [63:0] bk);
      chk($sformatf("d%0d_busy", d), 64'(b), 64'(m_busy[d]));
      chk($sformatf("d%0d_done", d), 64'(dn), 64'(m_doneo[d]));
      chk($sformatf("d%0d_mem_rd_en", d), 64'(rd), 64'(m_rd[d]));
      chk($sformatf("d%0d_mem_addr", d), 64'(a), 64'(m_addr[d]));
      chk($sformatf("d%0d_fft_enable", d), 64'(f), 64'(m_fft[d]));
      chk($sformatf("d%0d_cycle_count", d), 64'(c), 64'(m_cc[d]));
      chk($sformatf("d%0d_bank_num", d), bk, m_bank[d]);
   endtask

   // Advance the model at each active edge, then compare once outputs have settled.
   always @(posedge clk) begin
      model_step();
      #1;
      cmp(0, busy0, done0, rd0, addr0, fft0, cc0, bank0);
      cmp(1, busy1, done1, rd1, addr1, fft1, cc1, bank1);
   end

   // ---------------- directed and random stimulus ----------------
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy0 || busy1) && n < 60) begin
         tick();
         n++;
      end
      chk("idle_timeout", 64'(busy0 | busy1), 64'd0);
      tick();
   endtask

   initial begin
      bit found;
      rst_n = 1'b0; start = 1'b0; num = 12'd0; stall = 1'b0;
      tick(); tick(); tick();
      chk("rst_busy", 64'(busy0), 64'd0);
      chk("rst_rd", 64'(rd0), 64'd0);
      chk("rst_addr", 64'(addr0), 64'd0);
      chk("rst_bank", bank0, 64'd0);
      rst_n = 1'b1;
      tick();

      // Four chunks, no stall; a second start at cyc 3 must be ignored.
      start = 1'b1; num = 12'd4; tick(); start = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk("s1_rd", 64'(rd0), (k <= 4) ? 64'd1 : 64'd0);
         if (k <= 4) chk("s1_addr", 64'(addr0), 64'(k - 1));
         chk("s1_fft", 64'(fft0), (k >= 2 && k <= 5) ? 64'd1 : 64'd0);
         if (k >= 2 && k <= 5) chk("s1_cc", 64'(cc0), 64'(k - 2));
         chk("s1_done", 64'(done0), (k == 6) ? 64'd1 : 64'd0);
         chk("s1_busy", 64'(busy0), (k <= 6) ? 64'd1 : 64'd0);
         if (k == 3) begin
            chk("s2_lane0", 64'(bank0[3:0]), 64'd1);
            chk("s2_lane1", 64'(bank0[7:4]), 64'd2);
            chk("s2_lane14", 64'(bank0[59:56]), 64'd15);
            chk("s2_lane15", 64'(bank0[63:60]), 64'd0);
            start = 1'b0;
         end
         if (k == 2) begin start = 1'b1; num = 12'd9; end
      end
      wait_idle();

      // Empty pass on both latencies.
      start = 1'b1; num = 12'd0; tick(); start = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk("s4_rd", 64'(rd0), 64'd0);
         chk("s4_fft", 64'(fft0), 64'd0);
         chk("s4_done0", 64'(done0), (k == 2) ? 64'd1 : 64'd0);
         chk("s4_busy0", 64'(busy0), (k == 2) ? 64'd1 : 64'd0);
         chk("s4_done1", 64'(done1), (k == 2) ? 64'd1 : 64'd0);
      end
      wait_idle();

      // Two chunks: MEM_LAT=3 gives fft on cyc 4..5 and done on cyc 6.
      start = 1'b1; num = 12'd2; tick(); start = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         tick();
         chk("s4b_fft1", 64'(fft1), (k == 4 || k == 5) ? 64'd1 : 64'd0);
         chk("s4b_done1", 64'(done1), (k == 6) ? 64'd1 : 64'd0);
         chk("s4b_fft0", 64'(fft0), (k == 2 || k == 3) ? 64'd1 : 64'd0);
         chk("s4b_done0", 64'(done0), (k == 4) ? 64'd1 : 64'd0);
      end
      wait_idle();

      // Seventeen chunks: chunk 16 maps lanes to identity.
      start = 1'b1; num = 12'd17; tick(); start = 1'b0;
      found = 1'b0;
      for (int k = 1; k <= 40 && !found; k++) begin
         tick();
         if (fft0 && cc0 == 12'd16) begin
            chk("s2_identity", bank0, 64'hFEDC_BA98_7654_3210);
            found = 1'b1;
         end
      end
      chk("s2_identity_seen", 64'(found), 64'd1);
      wait_idle();

      // Stall on the edges of cyc 2 and 3.
      start = 1'b1; num = 12'd4; tick(); start = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         tick();
         chk("s3_rd", 64'(rd0), (k == 1 || (k >= 4 && k <= 6)) ? 64'd1 : 64'd0);
         if (k <= 6) chk("s3_addr", 64'(addr0), (k <= 3) ? 64'd0 : 64'(k - 3));
         chk("s3_fft", 64'(fft0), (k == 2 || (k >= 5 && k <= 7)) ? 64'd1 : 64'd0);
         chk("s3_done", 64'(done0), (k == 8) ? 64'd1 : 64'd0);
         if (k == 1) stall = 1'b1;
         if (k == 3) stall = 1'b0;
      end
      wait_idle();

      // Reset in the middle of a pass.
      start = 1'b1; num = 12'd8; tick(); start = 1'b0;
      tick(); tick(); tick();
      rst_n = 1'b0;
      #1;
      chk("s6_busy", 64'(busy0), 64'd0);
      chk("s6_rd", 64'(rd0), 64'd0);
      chk("s6_addr", 64'(addr0), 64'd0);
      chk("s6_fft", 64'(fft0), 64'd0);
      chk("s6_cc", 64'(cc0), 64'd0);
      chk("s6_bank", bank0, 64'd0);
      chk("s6_busy1", 64'(busy1), 64'd0);
      tick(); tick();
      rst_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
         tick();
         chk("s6_no_done0", 64'(done0), 64'd0);
         chk("s6_no_done1", 64'(done1), 64'd0);
      end
      start = 1'b1; num = 12'd3; tick(); start = 1'b0;
      tick();
      chk("s6_restart_rd", 64'(rd0), 64'd1);
      chk("s6_restart_addr", 64'(addr0), 64'd0);
      wait_idle();

      // Random traffic with occasional resets.
      for (int k = 0; k < 4000; k++) begin
         rst_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
         start = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
         num = ($urandom_range(0, 7) == 0) ? 12'd0 : 12'($urandom_range(1, 20));
         stall = ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0;
         tick();
      end
      rst_n = 1'b1; start = 1'b0; stall = 1'b0;
      for (int k = 0; k < 40; k++) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
